// File: rtl/vdp1_cmd_fetch_if.sv
// vdp1_cmd_fetch_if
// Bundles the two handshakes of the command fetcher. The first is the VRAM read port
// toward the arbiter. The second is the command hand-off toward the draw engine.
//   vram_a     [17:0] word address of the read
//   vram_rd           read request; address held stable until vram_rdy
//   vram_di    [15:0] read data, valid in the vram_rdy cycle
//   vram_rdy          read acknowledge
//   cmd       [255:0] current command table; word n sits at cmd[16*n +: 16]
//   cmd_valid         cmd is valid for the draw engine
//   cmd_ready         draw engine accepts cmd
// master: the fetcher. slave: the arbiter/draw-engine side.
interface vdp1_cmd_fetch_if;
    logic [17:0]  vram_a;
    logic         vram_rd;
    logic [15:0]  vram_di;
    logic         vram_rdy;
    logic [255:0] cmd;
    logic         cmd_valid;
    logic         cmd_ready;

    modport master (
        output vram_a, vram_rd, cmd, cmd_valid,
        input  vram_di, vram_rdy, cmd_ready
    );

    modport slave (
        input  vram_a, vram_rd, cmd, cmd_valid,
        output vram_di, vram_rdy, cmd_ready
    );
endinterface

// File: rtl/vdp1_cmd_fetch.sv
// vdp1_cmd_fetch
// VDP1 command-list reader. A plot trigger starts the walk at table 0. The reader
// then follows CMDCTRL.JP/CMDLINK (next, assign, call, return, skip) and stops at a
// table with END=1. Each drawable table goes to the draw engine as a masked 256-bit
// record. The block also keeps COPR/LOPR/CEF/BEF status for the register file.
//   clk, rst   system clock, asynchronous active-high reset
//   start      1-cycle plot trigger; restarts the walk at table 0 from any state
//   abort      1-cycle stop; back to idle, status held (start wins if both)
//   bus        vdp1_cmd_fetch_if.master: VRAM read port and command hand-off
//   copr       current table address / 8
//   lopr       address / 8 of the table that ended the last list
//   cef, bef   current / before frame end flags
//   busy       high whenever the walker is not idle
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | reading words 0..14 of table COPR, one per vram_rdy
// DECIDE | table complete; choose issue or skip
// ISSUE  | cmd_valid held until the draw engine takes the table
// NEXT   | advance COPR according to JP[1:0]
module vdp1_cmd_fetch #(
    parameter int RET_DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    vdp1_cmd_fetch_if.master bus,
    output logic [15:0]      copr,
    output logic [15:0]      lopr,
    output logic             cef,
    output logic             bef,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECIDE,
        S_ISSUE,
        S_NEXT
    } state_t;

    state_t      state, state_nxt;
    logic        rd_q, rd_nxt;
    logic [3:0]  idx;
    logic [15:0] tbl [0:14];
    logic [15:0] ret_q [RET_DEPTH];
    logic        ret_vld;

    logic        rd_ack;
    logic        end_hit;
    logic        last_word;
    logic        comm_ok;
    logic        issue_ok;
    logic [2:0]  jp;
    logic [3:0]  comm;
    logic [15:0] copr_inc;

    function automatic logic [15:0] field_mask(input logic [3:0] n);
        case (n)
            4'd0:    field_mask = 16'hFF3F;
            4'd1:    field_mask = 16'hFFFC;
            4'd2:    field_mask = 16'h9FFF;
            4'd4:    field_mask = 16'hFFFC;
            4'd5:    field_mask = 16'h3FFF;
            default: field_mask = 16'hFFFF;
        endcase
    endfunction

    // A vram_rdy that arrives while no request is up belongs to nobody
    // (for example the tail of a read cancelled by start/abort). It is dropped here.
    assign rd_ack    = rd_q && bus.vram_rdy;
    assign end_hit   = (idx == 4'd0) && bus.vram_di[15];
    assign last_word = (idx == 4'd14);

    assign jp       = tbl[0][14:12];
    assign comm     = tbl[0][3:0];
    assign copr_inc = copr + 16'd4;

    always_comb begin
        comm_ok = 1'b0;
        case (comm)
            4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA: comm_ok = 1'b1;
            default: comm_ok = 1'b0;
        endcase
    end

    assign issue_ok = !jp[2] && comm_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            rd_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            rd_q  <= rd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_nxt    = rd_q;
        if (start) begin
            // From idle the first read goes out right away. A restart from any
            // other state drops the request for one cycle first, so the arbiter
            // sees the old read withdrawn before the new address appears.
            state_nxt = S_FETCH;
            rd_nxt    = (state == S_IDLE);
        end else if (abort) begin
            state_nxt = S_IDLE;
            rd_nxt    = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    rd_nxt = 1'b0;
                end
                S_FETCH: begin
                    if (!rd_q) begin
                        rd_nxt = 1'b1;
                    end else if (rd_ack) begin
                        if (end_hit) begin
                            state_nxt = S_IDLE;
                            rd_nxt    = 1'b0;
                        end else if (last_word) begin
                            state_nxt = S_DECIDE;
                            rd_nxt    = 1'b0;
                        end
                    end
                end
                S_DECIDE: begin
                    state_nxt = issue_ok ? S_ISSUE : S_NEXT;
                end
                S_ISSUE: begin
                    if (bus.cmd_ready) begin
                        state_nxt = S_NEXT;
                    end
                end
                S_NEXT: begin
                    state_nxt = S_FETCH;
                    rd_nxt    = 1'b1;
                end
                default: begin
                    state_nxt = S_IDLE;
                    rd_nxt    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            copr    <= '0;
            lopr    <= '0;
            cef     <= 1'b0;
            bef     <= 1'b0;
            idx     <= '0;
            ret_vld <= 1'b0;
            for (int n = 0; n < 15; n++) begin
                tbl[n] <= '0;
            end
            for (int r = 0; r < RET_DEPTH; r++) begin
                ret_q[r] <= '0;
            end
        end else if (start) begin
            bef     <= cef;
            cef     <= 1'b0;
            copr    <= '0;
            ret_vld <= 1'b0;
            idx     <= '0;
        end else if (!abort) begin
            case (state)
                S_FETCH: begin
                    if (rd_ack) begin
                        tbl[idx] <= bus.vram_di & field_mask(idx);
                        if (end_hit) begin
                            lopr <= copr;
                            cef  <= 1'b1;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                S_NEXT: begin
                    idx <= '0;
                    case (jp[1:0])
                        2'b00: copr <= copr_inc;
                        2'b01: copr <= tbl[1];
                        2'b10: begin
                            // Single return register; a nested call simply overwrites it.
                            ret_q[0] <= copr_inc;
                            ret_vld  <= 1'b1;
                            copr     <= tbl[1];
                        end
                        default: begin
                            if (ret_vld) begin
                                copr    <= ret_q[0];
                                ret_vld <= 1'b0;
                            end else begin
                                copr <= copr_inc;
                            end
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.cmd = '0;
        for (int n = 0; n < 15; n++) begin
            bus.cmd[16*n +: 16] = tbl[n];
        end
    end

    assign bus.vram_a    = {copr, 2'b00} + {14'd0, idx};
    assign bus.vram_rd   = rd_q;
    assign bus.cmd_valid = (state == S_ISSUE);
    assign busy          = (state != S_IDLE);

endmodule
